// File: rtl/hack_pkg.sv
// hack_pkg: instruction field positions, jump codes and word width for the Hack core.
package hack_pkg;
  localparam int WORD_W = 16;
  localparam int OPC_BIT = 15;
  localparam int A_BIT = 12;
  localparam int COMP_MSB = 11;
  localparam int COMP_LSB = 6;
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;
  localparam int JMP_MSB = 2;
  localparam int JMP_LSB = 0;
  localparam logic [2:0] JGT = 3'b001;
  localparam logic [2:0] JEQ = 3'b010;
  localparam logic [2:0] JLT = 3'b100;
  localparam logic [2:0] JMP = 3'b111;
endpackage

// File: rtl/hack_cpu_core_if.sv
// hack_cpu_core_if: instruction/data memory bus between the Hack core (master) and memories (slave).
interface hack_cpu_core_if #(parameter int PC_W = 15);
  import hack_pkg::*;
  logic [WORD_W-1:0] instruction;
  logic instr_valid;
  logic [WORD_W-1:0] inM;
  logic [WORD_W-1:0] outM;
  logic writeM;
  logic [PC_W-1:0] addressM;
  logic [PC_W-1:0] pc;
  modport master(input instruction, instr_valid, inM, output outM, writeM, addressM, pc);
  modport slave(output instruction, instr_valid, inM, input outM, writeM, addressM, pc);
endinterface

// File: rtl/ALU.sv
// ALU: Hack 16-bit ALU with zero/negate preprocessing of both operands and optional output negate.
module ALU
  import hack_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic zx,
  input  logic nx,
  input  logic zy,
  input  logic ny,
  input  logic f,
  input  logic no,
  output logic [WORD_W-1:0] out,
  output logic zr,
  output logic ng
);
  logic [WORD_W-1:0] xz, xn, yz, yn, fo;
  always_comb begin
    xz = zx ? '0 : x;
    xn = nx ? ~xz : xz;
    yz = zy ? '0 : y;
    yn = ny ? ~yz : yz;
    fo = f ? xn + yn : xn & yn;
    out = no ? ~fo : fo;
    zr = out == '0;
    ng = out[WORD_W-1];
  end
endmodule

// File: rtl/hack_jump_unit.sv
// hack_jump_unit: resolves the j1/j2/j3 jump bits against the ALU flags.
module hack_jump_unit (
  input  logic [2:0] j,
  input  logic zr,
  input  logic ng,
  output logic take
);
  assign take = |(j & {ng, zr, ~(ng | zr)});
endmodule

// File: rtl/hack_cpu_core.sv
// hack_cpu_core: single-cycle Hack CPU owning A, D and PC; drives the ALU and resolves jumps.
module hack_cpu_core
  import hack_pkg::*;
#(
  parameter int PC_W = 15,
  parameter int RESET_PC = 0
) (
  input logic clk,
  input logic rst,
  hack_cpu_core_if.master bus
);
  logic [WORD_W-1:0] a_q, a_d, d_q, d_d, y, alu_out;
  logic [PC_W-1:0] pc_q, pc_d;
  logic is_c, zr, ng, take;
  logic [COMP_MSB-COMP_LSB:0] comp;
  assign is_c = bus.instruction[OPC_BIT];
  assign comp = bus.instruction[COMP_MSB:COMP_LSB];
  assign y = bus.instruction[A_BIT] ? bus.inM : a_q;
  ALU u_alu (
    .x(d_q), .y(y),
    .zx(comp[5]), .nx(comp[4]), .zy(comp[3]), .ny(comp[2]), .f(comp[1]), .no(comp[0]),
    .out(alu_out), .zr(zr), .ng(ng)
  );
  hack_jump_unit u_jump (.j(bus.instruction[JMP_MSB:JMP_LSB]), .zr(zr), .ng(ng), .take(take));
  // Operands and jump target come from pre-edge A/D, so A-write plus jump lands on the old A.
  always_comb begin
    a_d = !bus.instr_valid ? a_q : !is_c ? bus.instruction : bus.instruction[DEST_A] ? alu_out : a_q;
    d_d = (bus.instr_valid && is_c && bus.instruction[DEST_D]) ? alu_out : d_q;
    pc_d = !bus.instr_valid ? pc_q : (is_c && take) ? a_q[PC_W-1:0] : pc_q + PC_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      d_q <= '0;
      pc_q <= PC_W'(RESET_PC);
    end else begin
      a_q <= a_d;
      d_q <= d_d;
      pc_q <= pc_d;
    end
  end
  assign bus.outM = alu_out;
  assign bus.writeM = !rst && bus.instr_valid && is_c && bus.instruction[DEST_M];
  assign bus.addressM = a_q[PC_W-1:0];
  assign bus.pc = pc_q;
endmodule

// File: tb/tb_hack_cpu_core.sv
// tb_hack_cpu_core: directed-vector check of the Hack core with hand-computed expectations.
module tb_hack_cpu_core;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  hack_cpu_core_if #(.PC_W(15)) bus ();
  hack_cpu_core #(.PC_W(15), .RESET_PC(0)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] ins, input logic [15:0] m, input logic v);
    @(negedge clk);
    bus.instruction = ins;
    bus.inM = m;
    bus.instr_valid = v;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    bus.instr_valid = 0;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    bus.instruction = 16'h0000;
    bus.inM = 16'h0000;
    bus.instr_valid = 0;
    tick();
    tick();
    check("rst_pc", 32'(bus.pc), 32'h0);
    check("rst_writeM", 32'(bus.writeM), 32'h0);
    check("rst_addressM", 32'(bus.addressM), 32'h0);
    rst = 0;
    drive(16'hEC10, 16'h0, 1);
    check("rst_outM", 32'(bus.outM), 32'h0);
    tick();
    check("first_pc", 32'(bus.pc), 32'h1);

    do_reset();
    drive(16'h0070, 16'h0, 1); tick();
    drive(16'hEC10, 16'h0, 1); tick();
    drive(16'h0136, 16'h0, 1); tick();
    drive(16'hE088, 16'h0, 1);
    check("add_outM", 32'(bus.outM), 32'd422);
    check("add_writeM", 32'(bus.writeM), 32'h1);
    check("add_addressM", 32'(bus.addressM), 32'h136);
    tick();
    check("add_pc", 32'(bus.pc), 32'h4);

    do_reset();
    drive(16'h0014, 16'h0, 1); tick();
    drive(16'hFC10, 16'hFECA, 1);
    check("mem_writeM", 32'(bus.writeM), 32'h0);
    tick();
    drive(16'hE304, 16'h0, 1);
    check("jlt_outM", 32'(bus.outM), 32'hFECA);
    tick();
    check("jlt_taken_pc", 32'(bus.pc), 32'd20);

    do_reset();
    drive(16'h0014, 16'h0, 1); tick();
    drive(16'hFC10, 16'h0136, 1); tick();
    drive(16'hE304, 16'h0, 1); tick();
    check("jlt_nottaken_pc", 32'(bus.pc), 32'd3);

    do_reset();
    drive(16'h0005, 16'h0, 1); tick();
    drive(16'hEDE7, 16'h0, 1);
    check("oldA_outM", 32'(bus.outM), 32'h6);
    tick();
    check("oldA_pc", 32'(bus.pc), 32'h5);
    check("oldA_addressM", 32'(bus.addressM), 32'h6);

    do_reset();
    drive(16'h7FFF, 16'h0, 1); tick();
    drive(16'hE007, 16'h0, 1); tick();
    check("wrap_pre_pc", 32'(bus.pc), 32'h7FFF);
    drive(16'h0000, 16'h0, 1); tick();
    check("wrap_pc", 32'(bus.pc), 32'h0);

    do_reset();
    drive(16'h0070, 16'h0, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(16'hE088, 16'h0, 0);
      check("stall_writeM", 32'(bus.writeM), 32'h0);
      check("stall_outM", 32'(bus.outM), 32'h70);
      tick();
      check("stall_pc", 32'(bus.pc), 32'h1);
      check("stall_addressM", 32'(bus.addressM), 32'h70);
    end
    drive(16'hEC10, 16'h0, 1);
    check("post_stall_outM", 32'(bus.outM), 32'h70);
    tick();
    check("post_stall_pc", 32'(bus.pc), 32'h2);
    drive(16'hE088, 16'h0, 1);
    check("pre_rst_outM", 32'(bus.outM), 32'hE0);
    check("pre_rst_writeM", 32'(bus.writeM), 32'h1);
    rst = 1;
    #1;
    check("mid_rst_writeM", 32'(bus.writeM), 32'h0);
    tick();
    check("mid_rst_pc", 32'(bus.pc), 32'h0);
    check("mid_rst_addressM", 32'(bus.addressM), 32'h0);
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
